// File: rtl/voice_pkt_pkg.sv
// Shared constants, state encoding and header-word builders for the voice packet packer.
package voice_pkt_pkg;

  localparam logic [15:0] MAGIC_DEF = 16'hA55A;
  localparam int unsigned HDR_WORDS = 32'd3;
  localparam logic [15:0] HDR_BYTES = 16'(32'd2 * HDR_WORDS);

  localparam int unsigned OVF_BIT = 32'd15;
  localparam int unsigned CNT_MSB = 32'd14;
  localparam int unsigned FID_LSB = 32'd8;
  localparam int unsigned LID_MSB = 32'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_HDR0    = 3'd2,
    ST_HDR1    = 3'd3,
    ST_HDR2    = 3'd4,
    ST_PAYLOAD = 3'd5
  } pkt_state_e;

  function automatic logic [15:0] make_tag(input logic [7:0] fid, input logic [7:0] lid);
    logic [15:0] w;
    w = 16'h0000;
    w[15:FID_LSB] = fid;
    w[LID_MSB:0]  = lid;
    return w;
  endfunction

  function automatic logic [15:0] make_count(input logic ovf, input logic [14:0] cnt);
    logic [15:0] w;
    w = 16'h0000;
    w[OVF_BIT]    = ovf;
    w[CNT_MSB:0]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/voice_line_ram.sv
// One-line sample buffer: simple dual-port RAM with a registered read port.
module voice_line_ram #(
  parameter int unsigned ADDR_W = 32'd9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [15:0] mem_r [DEPTH];

  // write port and one-cycle-latency read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/voice_pkt_packer.sv
// Buffers one href line from the voice cache and replays it as a tagged packet
// (magic, frame/line tag, overflow/count, payload) on a valid/ready word stream.
module voice_pkt_packer
  import voice_pkt_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 32'd512,
  parameter int unsigned ADDR_W     = 32'd9,
  parameter logic [15:0] MAGIC      = MAGIC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        voice_vsync,
  input  logic        voice_href,
  input  logic [15:0] voice_data,
  output logic [15:0] pkt_data,
  output logic        pkt_valid,
  output logic        pkt_last,
  input  logic        pkt_ready,
  output logic [15:0] pkt_len,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  pkt_state_e  state_r;
  logic        href_d_r, vsync_d_r, ovf_r, dropping_r;
  logic [7:0]  frame_id_r, line_id_r, hdr_fid_r, hdr_lid_r;
  logic [15:0] wr_cnt_r, hdr_cnt_r, nxt_idx_r;
  logic        hdr_ovf_r;

  logic              href_rise_s, href_fall_s, vsync_rise_s, accept_s, room_s, line_inc_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s, raddr_s;
  logic [15:0]       rd_data_s;

  voice_line_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (voice_data),
    .raddr (raddr_s),
    .rdata (rd_data_s)
  );

  // edge detect, buffer write port and read-ahead address selection
  always_comb begin
    href_rise_s  = voice_href & ~href_d_r;
    href_fall_s  = ~voice_href & href_d_r;
    vsync_rise_s = voice_vsync & ~vsync_d_r;
    accept_s     = pkt_valid & pkt_ready;
    room_s       = (wr_cnt_r < 16'(LINE_WORDS));
    line_inc_s   = href_fall_s & ((state_r == ST_CAPTURE) | dropping_r);
    we_s         = 1'b0;
    waddr_s      = {ADDR_W{1'b0}};
    raddr_s      = nxt_idx_r[ADDR_W-1:0];
    // the read address always points at the word that must sit on rd_data after this edge
    case (state_r)
      ST_IDLE: begin
        if (voice_href && !dropping_r) begin
          we_s = 1'b1;
        end else begin
          we_s = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (voice_href && room_s) begin
          we_s    = 1'b1;
          waddr_s = wr_cnt_r[ADDR_W-1:0];
        end else begin
          we_s = 1'b0;
        end
      end
      ST_HDR1:    raddr_s = {ADDR_W{1'b0}};
      ST_HDR2:    raddr_s = accept_s ? ADDR_W'(32'd1) : {ADDR_W{1'b0}};
      ST_PAYLOAD: raddr_s = accept_s ? ADDR_W'(nxt_idx_r + 16'd1) : nxt_idx_r[ADDR_W-1:0];
      default:    raddr_s = {ADDR_W{1'b0}};
    endcase
  end

  // packet FSM, tag counters, drop accounting and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      href_d_r   <= 1'b0;
      vsync_d_r  <= 1'b0;
      frame_id_r <= 8'd0;
      line_id_r  <= 8'd0;
      wr_cnt_r   <= 16'd0;
      ovf_r      <= 1'b0;
      dropping_r <= 1'b0;
      hdr_fid_r  <= 8'd0;
      hdr_lid_r  <= 8'd0;
      hdr_cnt_r  <= 16'd0;
      hdr_ovf_r  <= 1'b0;
      nxt_idx_r  <= 16'd0;
      pkt_data   <= 16'h0000;
      pkt_valid  <= 1'b0;
      pkt_last   <= 1'b0;
      pkt_len    <= 16'd0;
      drop_cnt   <= 16'd0;
      busy       <= 1'b0;
    end else begin
      href_d_r  <= voice_href;
      vsync_d_r <= voice_vsync;

      if (vsync_rise_s) begin
        frame_id_r <= frame_id_r + 8'd1;
        line_id_r  <= 8'd0;
      end else if (line_inc_s) begin
        line_id_r <= line_id_r + 8'd1;
      end

      // a dropped line stays marked until its href falls so IDLE never picks up its tail
      if (href_rise_s && busy) begin
        dropping_r <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (href_fall_s) begin
        dropping_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (voice_href && !dropping_r) begin
            wr_cnt_r <= 16'd1;
            state_r  <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (voice_href) begin
            if (room_s) begin
              wr_cnt_r <= wr_cnt_r + 16'd1;
            end else begin
              ovf_r <= 1'b1;
            end
          end else begin
            hdr_fid_r <= frame_id_r;
            hdr_lid_r <= line_id_r;
            hdr_cnt_r <= wr_cnt_r;
            hdr_ovf_r <= ovf_r;
            pkt_len   <= HDR_BYTES + {wr_cnt_r[14:0], 1'b0};
            pkt_data  <= MAGIC;
            pkt_valid <= 1'b1;
            pkt_last  <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_HDR0;
          end
        end
        ST_HDR0: begin
          if (accept_s) begin
            pkt_data <= make_tag(hdr_fid_r, hdr_lid_r);
            state_r  <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (accept_s) begin
            pkt_data <= make_count(hdr_ovf_r, hdr_cnt_r[14:0]);
            state_r  <= ST_HDR2;
          end
        end
        ST_HDR2: begin
          if (accept_s) begin
            pkt_data  <= rd_data_s;
            pkt_last  <= (hdr_cnt_r == 16'd1);
            nxt_idx_r <= 16'd1;
            state_r   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (accept_s) begin
            if (pkt_last) begin
              pkt_data  <= 16'h0000;
              pkt_valid <= 1'b0;
              pkt_last  <= 1'b0;
              busy      <= 1'b0;
              wr_cnt_r  <= 16'd0;
              ovf_r     <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              pkt_data  <= rd_data_s;
              pkt_last  <= (nxt_idx_r == hdr_cnt_r - 16'd1);
              nxt_idx_r <= nxt_idx_r + 16'd1;
            end
          end
        end
        default: begin
          pkt_valid <= 1'b0;
          pkt_last  <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
